hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS integer pipeline.
- Watches IFIDIR, IDEXIR and MEMWBIR plus the decode stage's branchTaken.
- Drives decode's stall, IDEXAfromWB and IDEXBfromWB, the IF-stage hold and flush controls, and two stall/flush performance counters.
- Runs a small FSM so each load-use stall and each branch flush lasts a fixed, bounded number of cycles.

---
 rtl/pipeline_pkg.sv | 59 +++++
 rtl/hazard_detect.sv | 37 +++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, the canonical bubble, instruction
// field extractors and the hazard controller's FSM state type. Decode and
// the hazard controller both import this package so that they agree on
// encodings.
package pipeline_pkg;

  localparam logic [5:0] ALUop   = 6'd0;
  localparam logic [5:0] BEQ     = 6'd4;
  localparam logic [5:0] BEQINIT = 6'd20;
  localparam logic [5:0] LW      = 6'd35;
  localparam logic [5:0] SW      = 6'd43;

  // add r0,r0,r0 : the bubble inserted into IFIDIR/IDEXIR
  localparam logic [31:0] no_op = 32'h0000_0020;

  // Explicit encodings keep state values stable for anything that probes them.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } hz_state_t;

  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  // Conditional branches resolved in decode.
  function automatic logic is_branch(input logic [5:0] op);
    return (op == BEQ) || (op == BEQINIT);
  endfunction

  // Ops whose rt field names a source register.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == ALUop) || (op == SW) || (op == BEQ) || (op == BEQINIT);
  endfunction

  // Register written back by an instruction; 0 means "no destination"
  // (r0 is hardwired, so a write to it is no write at all).
  function automatic logic [4:0] wb_dest(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    if (op_of(ir) == ALUop) d = rd_of(ir);
    else if (op_of(ir) == LW) d = rt_of(ir);
    return d;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load-use hazard between EX and ID, and
// write-back bypass selection for the ID-stage operands.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [31:0] IFIDIR,
  input  logic [31:0] IDEXIR,
  input  logic [31:0] MEMWBIR,
  output logic        load_hazard,
  output logic        a_from_wb,
  output logic        b_from_wb
);

  logic [4:0] ex_rt;
  logic [4:0] wb_d;
  logic       ex_is_load;
  logic       rs_match;
  logic       rt_match;

  // Load in EX whose target is read by the instruction in ID.
  always_comb begin
    ex_rt      = rt_of(IDEXIR);
    ex_is_load = (op_of(IDEXIR) == LW) && (ex_rt != 5'd0);
    // A bubble reads nothing, even though its rs field happens to be r0.
    rs_match   = (IFIDIR != no_op) && (ex_rt == rs_of(IFIDIR));
    rt_match   = reads_rt(op_of(IFIDIR)) && (ex_rt == rt_of(IFIDIR));
    load_hazard = ex_is_load && (rs_match || rt_match);
  end

  // Operand bypass from the write-back stage result.
  always_comb begin
    wb_d      = wb_dest(MEMWBIR);
    a_from_wb = (wb_d != 5'd0) && (wb_d == rs_of(IFIDIR));
    b_from_wb = (wb_d != 5'd0) && (wb_d == rt_of(IFIDIR));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: bounded load-use stall,
// multi-cycle branch flush, WB bypass selects and stall/flush counters.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal issue; load-use stall or branch flush may start
// LD_STALL | bubble now in EX; hazard check off, branch may start
// BR_FLUSH | remaining flush cycles of a taken branch (brk_cnt left)
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IFIDIR,
  input  logic [31:0]      IDEXIR,
  input  logic [31:0]      MEMWBIR,
  input  logic             branchTaken,
  output logic             stall,
  output logic             pc_hold,
  output logic             if_flush,
  output logic             IDEXAfromWB,
  output logic             IDEXBfromWB,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The first flush cycle is spent in RUN/LD_STALL, the rest in BR_FLUSH.
  localparam logic [2:0] BRK_LOAD = 3'(BRANCH_PENALTY - 1);
  localparam logic       MULTI    = (BRANCH_PENALTY > 1);

  hz_state_t  state, state_nxt;
  logic [2:0] brk_cnt, brk_nxt;
  logic       load_hazard;
  logic       a_raw, b_raw;
  logic       br_go;
  logic       stall_c, flush_c;

  hazard_detect u_detect (
    .IFIDIR      (IFIDIR),
    .IDEXIR      (IDEXIR),
    .MEMWBIR     (MEMWBIR),
    .load_hazard (load_hazard),
    .a_from_wb   (a_raw),
    .b_from_wb   (b_raw)
  );

  assign br_go = branchTaken && is_branch(op_of(IFIDIR));

  // Next-state and raw control decode; load hazard outranks a branch.
  always_comb begin
    state_nxt = state;
    brk_nxt   = brk_cnt;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    case (state)
      RUN: begin
        if (load_hazard) begin
          stall_c   = 1'b1;
          state_nxt = LD_STALL;
        end else if (br_go) begin
          flush_c = 1'b1;
          if (MULTI) begin
            state_nxt = BR_FLUSH;
            brk_nxt   = BRK_LOAD;
          end
        end
      end
      LD_STALL: begin
        state_nxt = RUN;
        if (br_go) begin
          flush_c = 1'b1;
          if (MULTI) begin
            state_nxt = BR_FLUSH;
            brk_nxt   = BRK_LOAD;
          end
        end
      end
      BR_FLUSH: begin
        flush_c = 1'b1;
        if (brk_cnt <= 3'd1) begin
          state_nxt = RUN;
          brk_nxt   = 3'd0;
        end else begin
          brk_nxt = brk_cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        brk_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are quiet for as long as reset is held.
  always_comb begin
    stall       = stall_c & ~reset;
    pc_hold     = stall_c & ~reset;
    if_flush    = flush_c & ~reset;
    IDEXAfromWB = a_raw & ~reset;
    IDEXBfromWB = b_raw & ~reset;
  end

  // FSM state and flush down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      brk_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      brk_cnt <= brk_nxt;
    end
  end

  // Performance counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall)    stall_count <= stall_count + CNT_W'(1);
      if (if_flush) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized instruction streams, all compared against a behavioural model.
module tb_hazard_ctrl;
  import pipeline_pkg::BEQINIT;

  localparam int PEN = 3;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IFIDIR, IDEXIR, MEMWBIR;
  logic        branchTaken;
  logic        stall, pc_hold, if_flush, IDEXAfromWB, IDEXBfromWB;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl #(.BRANCH_PENALTY(PEN), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .IFIDIR      (IFIDIR),
    .IDEXIR      (IDEXIR),
    .MEMWBIR     (MEMWBIR),
    .branchTaken (branchTaken),
    .stall       (stall),
    .pc_hold     (pc_hold),
    .if_flush    (if_flush),
    .IDEXAfromWB (IDEXAfromWB),
    .IDEXBfromWB (IDEXBfromWB),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: flush cycles still owed, "previous cycle stalled", counters
  int          m_rem  = 0;
  bit          m_post = 0;
  logic [31:0] m_sc   = 0;
  logic [31:0] m_fc   = 0;

  // last sampled combinational outputs
  logic o_stall, o_flush, o_a, o_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt, input int fn);
    rtype = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int dest(input logic [31:0] ir);
    int op;
    op = int'(ir[31:26]);
    if (op == 0) return int'(ir[15:11]);
    if (op == 35) return int'(ir[20:16]);
    return 0;
  endfunction

  function automatic bit load_use(input logic [31:0] ex, input logic [31:0] id);
    int t, op;
    bit rt_src;
    t  = int'(ex[20:16]);
    op = int'(id[31:26]);
    rt_src = (op == 0) || (op == 43) || (op == 4) || (op == int'(BEQINIT));
    if (int'(ex[31:26]) != 35 || t == 0) return 0;
    return ((id != NOP) && t == int'(id[25:21])) || (rt_src && t == int'(id[20:16]));
  endfunction

  task automatic step(input logic rst, input logic [31:0] id, input logic [31:0] ex,
                      input logic [31:0] wb, input logic bt);
    bit e_stall, e_flush, e_a, e_b;
    int d, op;
    @(negedge clk);
    reset = rst; IFIDIR = id; IDEXIR = ex; MEMWBIR = wb; branchTaken = bt;
    d  = dest(wb);
    op = int'(id[31:26]);
    e_a = !rst && d != 0 && d == int'(id[25:21]);
    e_b = !rst && d != 0 && d == int'(id[20:16]);
    e_stall = 0; e_flush = 0;
    if (!rst) begin
      if (m_rem > 0) e_flush = 1;
      else if (!m_post && load_use(ex, id)) e_stall = 1;
      else if (bt && (op == 4 || op == int'(BEQINIT))) e_flush = 1;
    end
    #1;
    o_stall = stall; o_flush = if_flush; o_a = IDEXAfromWB; o_b = IDEXBfromWB;
    check("stall", stall, e_stall);
    check("pc_hold", pc_hold, e_stall);
    check("if_flush", if_flush, e_flush);
    check("a_from_wb", IDEXAfromWB, e_a);
    check("b_from_wb", IDEXBfromWB, e_b);
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_post = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_sc = m_sc + 32'(e_stall);
      m_fc = m_fc + 32'(e_flush);
      if (m_rem > 0) m_rem--;
      else if (e_flush) m_rem = PEN - 1;
      m_post = e_stall;
    end
    #1;
    check("stall_count", stall_count, m_sc);
    check("flush_count", flush_count, m_fc);
  endtask

  function automatic logic [31:0] rand_ir();
    int sel, rs, rt, rd;
    sel = int'($urandom_range(0, 7));
    rs  = int'($urandom_range(0, 3));
    rt  = int'($urandom_range(0, 3));
    rd  = int'($urandom_range(0, 3));
    case (sel)
      0, 1:    return rtype(rd, rs, rt, 32);
      2:       return itype(35, rs, rt, 4);
      3:       return itype(43, rs, rt, 8);
      4:       return itype(4, rs, rt, 2);
      5:       return itype(int'(BEQINIT), rs, rt, 2);
      6:       return itype(8, rs, rt, 1);
      default: return NOP;
    endcase
  endfunction

  initial begin
    logic [31:0] lw2, add3, beq;
    reset = 1'b1; IFIDIR = NOP; IDEXIR = NOP; MEMWBIR = NOP; branchTaken = 1'b0;

    step(1, NOP, NOP, NOP, 0);
    step(1, NOP, NOP, NOP, 0);
    check("reset_stall_count", stall_count, 0);
    check("reset_flush_count", flush_count, 0);

    // load-use: lw r2,0(r1) in EX, add r3,r2,r4 in ID
    lw2  = itype(35, 1, 2, 0);
    add3 = rtype(3, 2, 4, 32);
    step(0, add3, lw2, NOP, 0);
    check("lu_stall_c1", o_stall, 1);
    step(0, add3, NOP, NOP, 0);
    check("lu_stall_c2", o_stall, 0);
    check("lu_stall_count", stall_count, 1);

    // load to r0 never stalls
    step(0, rtype(3, 0, 0, 32), itype(35, 1, 0, 0), NOP, 0);
    check("r0_no_stall", o_stall, 0);

    // WB bypass: add r5,r6,r7 in WB, sub r8,r5,r5 in ID
    step(0, rtype(8, 5, 5, 34), NOP, rtype(5, 6, 7, 32), 0);
    check("byp_a", o_a, 1);
    check("byp_b", o_b, 1);
    check("byp_no_stall", o_stall, 0);

    // taken branch: exactly PEN flush cycles
    step(1, NOP, NOP, NOP, 0);
    beq = itype(4, 1, 2, 4);
    for (int i = 0; i < PEN; i++) begin
      step(0, beq, NOP, NOP, 1);
      check("br_flush_on", o_flush, 1);
    end
    check("br_flush_count", flush_count, PEN);
    step(0, NOP, NOP, NOP, 0);
    check("br_flush_off", o_flush, 0);

    // load hazard and taken branch together: stall first, then flush
    step(1, NOP, NOP, NOP, 0);
    step(0, itype(4, 2, 3, 0), lw2, NOP, 1);
    check("both_c1_stall", o_stall, 1);
    check("both_c1_flush", o_flush, 0);
    step(0, itype(4, 2, 3, 0), NOP, NOP, 1);
    check("both_c2_flush", o_flush, 1);
    check("both_c2_stall", o_stall, 0);
    step(0, NOP, NOP, NOP, 0);
    step(0, NOP, NOP, NOP, 0);

    // reset during the second BR_FLUSH cycle
    step(1, NOP, NOP, NOP, 0);
    step(0, beq, NOP, NOP, 1);
    step(0, NOP, NOP, NOP, 0);
    step(1, NOP, NOP, NOP, 0);
    step(0, NOP, NOP, NOP, 0);
    check("rst_mid_flush", o_flush, 0);
    check("rst_mid_sc", stall_count, 0);
    check("rst_mid_fc", flush_count, 0);
    step(0, add3, lw2, NOP, 0);
    check("rst_mid_run", o_stall, 1);

    // randomized streams
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), rand_ir(), rand_ir(), rand_ir(),
           ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
